fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - ADDR_W, 5, PC width; instruction memory depth is 2**ADDR_W.
  - RESET_PC, 0, PC value loaded on reset and on start.
  - CNT_W, 8, retired-instruction counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, single clock; all state updates on rising edge.
  - reset, in, 1, asynchronous, active-high.
  - start, in, 1, one-cycle pulse; begins execution from RESET_PC.
  - step_mode, in, 1, 1 = single-step, 0 = free-run.
  - step, in, 1, one-cycle pulse; commits one instruction in step mode.
  - instr, in, 16, instruction word returned combinationally by instruction memory for pc.
  - branch_eq, in, 1, datapath comparator result (rf[instr[7:4]] == rf[instr[3:0]]) for the current instr.
  - pc, out, ADDR_W, registered program counter; drives instruction memory read_addr.
  - exec_en, out, 1, combinational; current instr commits at the next rising edge.
  - halted, out, 1, registered; 1 while in HALT.
  - state, out, 2, registered FSM state: IDLE=00, RUN=01, HALT=10.
  - retired, out, CNT_W, count of committed instructions.
REQ-003 One clock only; reset is asynchronous and active-high, named clk and reset.

Function
REQ-004 Opcode = instr[15:13]; 3'b101 = branch, target = instr[12:8]; 3'b111 = halt; all others are sequential.
REQ-005 FSM states: IDLE, RUN, HALT; state 2'b11 is unreachable and recovers to IDLE on the next edge.
REQ-006 IDLE: pc holds, exec_en=0; start=1 -> pc<=RESET_PC, retired<=0, RUN.
REQ-007 RUN: advance = ~step_mode | step; exec_en = advance & (opcode != 111).
REQ-008 RUN, advance=0: pc, retired and state hold.
REQ-009 RUN, advance=1, opcode 111: pc holds, retired holds, state<=HALT; the halt is not counted.
REQ-010 RUN, exec_en=1, opcode 101 with branch_eq=1: pc<=instr[12:8]; otherwise pc<=pc+1.
REQ-011 pc+1 wraps modulo 2**ADDR_W: 31 -> 0 with ADDR_W=5.
REQ-012 RUN, exec_en=1: retired<=retired+1, saturating at 2**CNT_W-1.
REQ-013 Branch is single-cycle with no delay slot; the target instr is presented in the cycle after the branch commits.
REQ-014 start in RUN is ignored; step outside RUN is ignored; step is ignored in RUN when step_mode=0.
REQ-015 HALT: exec_en=0, halted=1, pc and retired hold; start=1 -> pc<=RESET_PC, retired<=0, RUN.
REQ-016 step_mode may change on any cycle and takes effect in the same cycle's exec_en.
REQ-017 exec_en and halted never assert together.

Reset
REQ-018 reset=1 asynchronously forces pc=RESET_PC, state=IDLE, halted=0, retired=0; exec_en is 0 while reset is held.
REQ-019 Reset asserted mid-RUN discards any in-flight commit; after release the block waits in IDLE for start.

Verification
REQ-020 Reset, then start pulse, step_mode=0, instrs at 0..3 are load-immediate -> pc 0,1,2,3,4 on successive cycles; exec_en=1; retired=4 after four edges.
REQ-021 Branch at pc=18, instr=16'b101_01011_0000_0000, branch_eq=1 -> next pc=11, retired +1; same instr with branch_eq=0 -> next pc=19.
REQ-022 Halt at pc=20, instr=16'hFFFF -> exec_en=0; next edge state=10, halted=1, pc=20; retired unchanged; later start -> pc=0, retired=0, state=01.
REQ-023 step_mode=1, no step for 5 cycles -> pc and retired frozen; three single-cycle step pulses -> pc advances exactly 3.
REQ-024 Free-run with sequential instrs from pc=31 -> pc wraps to 0; hold 300 sequential instrs -> retired saturates at 255.
REQ-025 Assert reset asynchronously mid-cycle during RUN at pc=9 -> outputs go to reset values before the next edge; start after release restarts at pc=0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC sequencer with IDLE/RUN/HALT control, single-step support,
//            branch/halt decode and a saturating retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic [15:0]       instr,
    input  logic              branch_eq,
    output logic [ADDR_W-1:0] pc,
    output logic              exec_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_BAD  = 2'b11
    } t_state;

    localparam logic [2:0]        c_OP_BRANCH = 3'b101;
    localparam logic [2:0]        c_OP_HALT   = 3'b111;
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    t_state             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   r_retired;
    logic               r_halted;

    t_state             w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [CNT_W-1:0]   w_retired_nxt;
    logic [2:0]         w_opcode;
    logic               w_advance;
    logic               w_is_halt;
    logic               w_take_branch;
    logic               w_exec_en;
    logic [ADDR_W-1:0]  w_target;
    logic               w_unused;

    // Operand fields are consumed by the datapath, not by the sequencer.
    assign w_unused = ^instr[7:0];

    assign w_opcode      = instr[15:13];
    assign w_advance     = ~step_mode | step;
    assign w_is_halt     = (w_opcode == c_OP_HALT);
    assign w_take_branch = (w_opcode == c_OP_BRANCH) & branch_eq;
    assign w_target      = ADDR_W'(instr[12:8]);
    assign w_exec_en     = (r_state == S_RUN) & w_advance & ~w_is_halt;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_retired_nxt = r_retired;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_pc_nxt      = RESET_PC;
                    w_retired_nxt = '0;
                end
            end
            S_RUN: begin
                if (w_advance && w_is_halt) begin
                    // The halt itself is not a committed instruction.
                    w_state_nxt = S_HALT;
                end else if (w_exec_en) begin
                    w_pc_nxt = w_take_branch ? w_target : (r_pc + c_PC_ONE);
                    if (r_retired != c_CNT_MAX) begin
                        w_retired_nxt = r_retired + c_CNT_ONE;
                    end
                end
            end
            S_BAD: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_retired <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_retired <= w_retired_nxt;
            r_halted  <= (w_state_nxt == S_HALT);
        end
    end

    assign pc      = r_pc;
    assign exec_en = w_exec_en;
    assign halted  = r_halted;
    assign state   = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed vector table,
//            corner-case sequences and random stimulus against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [15:0] instr;
    logic        branch_eq;
    logic [4:0]  pc;
    logic        exec_en;
    logic        halted;
    logic [1:0]  state;
    logic [7:0]  retired;

    logic [15:0] imem [32];
    logic        use_mem;
    logic [15:0] instr_drv;

    int n_cmp;
    int n_err;

    // Reference model: 0 = idle, 1 = run, 2 = halt
    int m_state;
    int m_pc;
    int m_ret;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .instr     (instr),
        .branch_eq (branch_eq),
        .pc        (pc),
        .exec_en   (exec_en),
        .halted    (halted),
        .state     (state),
        .retired   (retired)
    );

    assign instr = use_mem ? imem[pc] : instr_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        sm;
        logic        sp;
        logic [15:0] ins;
        logic        beq;
        logic        exp_en;
        logic [4:0]  exp_pc;
        logic [1:0]  exp_state;
        logic [7:0]  exp_ret;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic st, input logic sm, input logic sp,
                                input logic [15:0] ins, input logic beq,
                                input logic en, input logic [4:0] epc,
                                input logic [1:0] est, input logic [7:0] eret);
        vec_t v;
        v.st = st; v.sm = sm; v.sp = sp; v.ins = ins; v.beq = beq;
        v.exp_en = en; v.exp_pc = epc; v.exp_state = est; v.exp_ret = eret;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_ret   = 0;
    endtask

    // One clock cycle: drive, check the combinational commit flag, clock, check state.
    task automatic drive_cycle(input logic st, input logic sm, input logic sp,
                               input logic beq, input logic [15:0] ins_f,
                               input bit from_mem);
        logic [15:0] ins;
        int  op;
        bit  adv;
        bit  en;
        @(negedge clk);
        start = st; step_mode = sm; step = sp; branch_eq = beq;
        use_mem = from_mem; instr_drv = ins_f;
        ins = from_mem ? imem[m_pc] : ins_f;
        op  = int'(ins[15:13]);
        adv = !sm || sp;
        en  = (m_state == 1) && adv && (op != 7);
        #1;
        chk("exec_en", int'(exec_en), int'(en));
        chk("exclusive", int'(exec_en && halted), 0);
        @(posedge clk);
        if (m_state == 1) begin
            if (adv && op == 7) begin
                m_state = 2;
            end else if (en) begin
                if (op == 5 && beq) m_pc = int'(ins[12:8]);
                else                m_pc = (m_pc + 1) % 32;
                if (m_ret < 255) m_ret = m_ret + 1;
            end
        end else if (st) begin
            m_state = 1;
            m_pc    = 0;
            m_ret   = 0;
        end
        #1;
        chk("pc", int'(pc), m_pc);
        chk("state", int'(state), m_state);
        chk("halted", int'(halted), int'(m_state == 2));
        chk("retired", int'(retired), m_ret);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0; step = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; branch_eq = 1'b0;
        use_mem = 1'b0; instr_drv = 16'h0000;
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
        model_reset();

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_exec_en", int'(exec_en), 0);
        @(negedge clk);
        reset = 1'b0;

        //          st  sm  sp  ins       beq en  pc  state  ret
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0,  0, 2'b01, 0);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 1,  1, 2'b01, 1);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 0, 1,  2, 2'b01, 2);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 1,  3, 2'b01, 3);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 1,  4, 2'b01, 4);
        tbl[5]  = mk(0, 0, 0, 16'hB200, 1, 1, 18, 2'b01, 5);
        tbl[6]  = mk(0, 0, 0, 16'hAB00, 1, 1, 11, 2'b01, 6);
        tbl[7]  = mk(0, 0, 0, 16'hB200, 1, 1, 18, 2'b01, 7);
        tbl[8]  = mk(0, 0, 0, 16'hAB00, 0, 1, 19, 2'b01, 8);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 1, 20, 2'b01, 9);
        tbl[10] = mk(0, 0, 0, 16'hFFFF, 0, 0, 20, 2'b10, 9);
        tbl[11] = mk(0, 0, 1, 16'hFFFF, 0, 0, 20, 2'b10, 9);
        tbl[12] = mk(1, 0, 0, 16'hFFFF, 0, 0,  0, 2'b01, 0);
        tbl[13] = mk(0, 1, 0, 16'h0000, 0, 0,  0, 2'b01, 0);
        tbl[14] = mk(0, 1, 1, 16'h0000, 0, 1,  1, 2'b01, 1);
        tbl[15] = mk(1, 0, 0, 16'h0000, 0, 1,  2, 2'b01, 2);
        tbl[16] = mk(0, 1, 1, 16'hB200, 1, 1, 18, 2'b01, 3);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start = tbl[i].st; step_mode = tbl[i].sm; step = tbl[i].sp;
            instr_drv = tbl[i].ins; branch_eq = tbl[i].beq; use_mem = 1'b0;
            #1;
            chk("vec_exec_en", int'(exec_en), int'(tbl[i].exp_en));
            @(posedge clk);
            #1;
            chk("vec_pc", int'(pc), int'(tbl[i].exp_pc));
            chk("vec_state", int'(state), int'(tbl[i].exp_state));
            chk("vec_retired", int'(retired), int'(tbl[i].exp_ret));
            chk("vec_halted", int'(halted), int'(tbl[i].exp_state == 2'b10));
        end

        // Step mode: frozen without step, then three isolated step pulses
        do_reset();
        drive_cycle(1, 0, 0, 0, 16'h0000, 0);
        repeat (5) drive_cycle(0, 1, 0, 0, 16'h0000, 0);
        chk("frozen_pc", int'(pc), 0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 1, 1, 0, 16'h0000, 0);
            drive_cycle(0, 1, 0, 0, 16'h0000, 0);
        end
        chk("step3_pc", int'(pc), 3);
        chk("step3_ret", int'(retired), 3);

        // PC wrap from 31 and counter saturation
        drive_cycle(0, 0, 0, 1, 16'hBF00, 0);
        chk("at31", int'(pc), 31);
        drive_cycle(0, 0, 0, 0, 16'h0000, 0);
        chk("wrap", int'(pc), 0);
        repeat (300) drive_cycle(0, 0, 0, 0, 16'h2000, 0);
        chk("saturate", int'(retired), 255);

        // Asynchronous reset in the middle of a RUN cycle at pc=9
        drive_cycle(0, 0, 0, 1, 16'hA900, 0);
        chk("at9", int'(pc), 9);
        @(negedge clk);
        instr_drv = 16'h0000; use_mem = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", int'(pc), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_retired", int'(retired), 0);
        chk("arst_exec_en", int'(exec_en), 0);
        chk("arst_halted", int'(halted), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_cycle(0, 0, 0, 0, 16'h0000, 0);
        drive_cycle(1, 0, 0, 0, 16'h0000, 0);
        chk("restart_pc", int'(pc), 0);
        chk("restart_state", int'(state), 1);

        // Random program and control stimulus against the model
        for (int i = 0; i < 32; i++) begin
            int r;
            int ops [6];
            ops = '{0, 1, 2, 3, 4, 6};
            r = int'($urandom_range(0, 9));
            if (r == 0)      imem[i] = {3'b111, 13'($urandom)};
            else if (r <= 3) imem[i] = {3'b101, 13'($urandom)};
            else             imem[i] = {3'(ops[$urandom_range(0, 5)]), 13'($urandom)};
        end
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(($urandom_range(0, 15) == 0),
                        ($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)),
                        16'h0000, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
